// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: shared constants, FSM states and shadow-stage metadata for the hazard/forwarding controller
package hazard_forward_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(31);
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, FREEZE} state_t;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;
  localparam stage_t STAGE_NONE = '0;
  // true when stage s will write register r and that write is worth tracking (XZR never is)
  function automatic logic writes(stage_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && s.rd != ZERO_REG && s.rd == r;
  endfunction
endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// hazard_forward_ctrl_fwd_select: per-operand comparator against the EX and MEM shadow entries
module hazard_forward_ctrl_fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses,
  input  stage_t                ex_s,
  input  stage_t                mem_s,
  output logic [1:0]            sel,
  output logic                  load_hit
);
  // EX/MEM result is newer than WB, so it wins; unused operands never forward or stall
  always_comb begin
    sel = !uses ? FWD_REGFILE : writes(ex_s, rs) ? FWD_EXMEM : writes(mem_s, rs) ? FWD_WB : FWD_REGFILE;
    load_hit = uses && writes(ex_s, rs) && ex_s.mem_read;
  end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-stage forwarding selects, load-use stall, branch flush and memory freeze sequencing (optional counters: HAZARD_PERF_EN)
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  mem_branch_taken,
  input  logic                  mem_busy,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt,
`endif
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB
);
  state_t state, nxt;
  stage_t id_s, ex_s, mem_s;
  logic [1:0] sel_a, sel_b;
  logic hit_a, hit_b;
  assign id_s = {id_valid, id_reg_write, id_mem_read, id_rd};
  hazard_forward_ctrl_fwd_select u_sel_a (
    .rs(id_rn), .uses(id_uses_rn), .ex_s(ex_s), .mem_s(mem_s), .sel(sel_a), .load_hit(hit_a)
  );
  hazard_forward_ctrl_fwd_select u_sel_b (
    .rs(id_rm), .uses(id_uses_rm), .ex_s(ex_s), .mem_s(mem_s), .sel(sel_b), .load_hit(hit_b)
  );
  // busy memory outranks a taken branch, which outranks a load-use hazard
  always_comb nxt = mem_busy ? FREEZE : mem_branch_taken ? FLUSH : (id_valid && (hit_a || hit_b)) ? LOAD_STALL : RUN;
  // advance the shadow pipeline and register the forward selects for the instruction entering EX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      ex_s <= STAGE_NONE;
      mem_s <= STAGE_NONE;
      forwardA <= FWD_REGFILE;
      forwardB <= FWD_REGFILE;
    end else begin
      state <= nxt;
      ex_s <= nxt == FREEZE ? ex_s : (nxt == RUN && id_valid) ? id_s : STAGE_NONE;
      mem_s <= nxt == FREEZE ? mem_s : nxt == FLUSH ? STAGE_NONE : ex_s;
      forwardA <= nxt == FREEZE ? forwardA : nxt == RUN ? sel_a : FWD_REGFILE;
      forwardB <= nxt == FREEZE ? forwardB : nxt == RUN ? sel_b : FWD_REGFILE;
    end
  end
  assign pc_write = state == RUN || state == FLUSH;
  assign if_id_write = state == RUN || state == FLUSH;
  assign id_ex_bubble = state == LOAD_STALL;
  assign flush_if_id = state == FLUSH;
  assign flush_id_ex = state == FLUSH;
  assign flush_ex_mem = state == FLUSH;
`ifdef HAZARD_PERF_EN
  // one tick per cycle spent in each non-RUN state, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      freeze_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(state == LOAD_STALL);
      flush_cnt <= flush_cnt + CNT_W'(state == FLUSH);
      freeze_cnt <= freeze_cnt + CNT_W'(state == FREEZE);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard bench with an instruction-history reference model
module tb_hazard_forward_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_uses_rn = 1'b0, id_uses_rm = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic mem_branch_taken = 1'b0, mem_busy = 1'b0;
  logic pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] forwardA, forwardB;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif
  hazard_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
`endif
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .forwardA(forwardA), .forwardB(forwardB)
  );
  always #5 clk = ~clk;
  // an issued instruction as seen by later ones: does it write, is it a load, which register
  typedef struct {bit w; bit ld; int rd;} instr_t;
  typedef struct {logic [5:0] ctl; logic [1:0] fa; logic [1:0] fb; int unsigned sc; int unsigned fc; int unsigned zc;} xp_t;
  xp_t xp_q[$];
  instr_t older[2];
  int cur_mode = 0;
  logic [1:0] m_fa = 2'b00, m_fb = 2'b00;
  int unsigned m_sc = 0, m_fc = 0, m_zc = 0;
  int compared = 0, mismatched = 0;
  // {pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, flush_ex_mem} for run, stall, flush, freeze
  logic [5:0] ctl_of [4] = '{6'b110000, 6'b001000, 6'b110111, 6'b000000};
  function automatic bit produces(instr_t i, int r);
    return i.w && i.rd != 31 && i.rd == r;
  endfunction
  // older[0] was issued one advance ago, older[1] two ago
  function automatic logic [1:0] pick(int r, bit u);
    if (!u) return 2'b00;
    if (produces(older[0], r)) return 2'b10;
    if (produces(older[1], r)) return 2'b01;
    return 2'b00;
  endfunction
  task automatic model_edge();
    instr_t none;
    xp_t e;
    int ns;
    none = '{0, 0, 0};
    if (!rst_n) begin
      older[0] = none; older[1] = none; ns = 0;
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_zc = 0;
    end else begin
      m_sc += (cur_mode == 1) ? 1 : 0;
      m_fc += (cur_mode == 2) ? 1 : 0;
      m_zc += (cur_mode == 3) ? 1 : 0;
      if (mem_busy) ns = 3;
      else if (mem_branch_taken) begin
        ns = 2; older[0] = none; older[1] = none; m_fa = 0; m_fb = 0;
      end else if (id_valid && older[0].ld && ((id_uses_rn && produces(older[0], int'(id_rn))) || (id_uses_rm && produces(older[0], int'(id_rm))))) begin
        ns = 1; older[1] = older[0]; older[0] = none; m_fa = 0; m_fb = 0;
      end else begin
        ns = 0;
        m_fa = pick(int'(id_rn), id_uses_rn);
        m_fb = pick(int'(id_rm), id_uses_rm);
        older[1] = older[0];
        older[0] = id_valid ? '{id_reg_write, id_mem_read, int'(id_rd)} : none;
      end
    end
    cur_mode = ns;
    e.ctl = ctl_of[ns]; e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc; e.zc = m_zc;
    xp_q.push_back(e);
  endtask
  task automatic issue(bit v, int rn, bit urn, int rm, bit urm, int rd, bit rw, bit ld, bit br, bit busy);
    logic [31:0] a, b, d;
    a = rn; b = rm; d = rd;
    id_valid = v; id_rn = a[4:0]; id_uses_rn = urn; id_rm = b[4:0]; id_uses_rm = urm;
    id_rd = d[4:0]; id_reg_write = rw; id_mem_read = ld; mem_branch_taken = br; mem_busy = busy;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk(string nm, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask
  // monitor: outputs are presented every cycle, so one expectation is due per edge
  always @(negedge clk) begin
    xp_t e;
    if (xp_q.size() > 0) begin
      e = xp_q.pop_front();
      chk("ctl", {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem}, e.ctl);
      chk("forwardA", forwardA, e.fa);
      chk("forwardB", forwardB, e.fb);
`ifdef HAZARD_PERF_EN
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
      chk("freeze_cnt", freeze_cnt, e.zc);
`endif
    end
  end
  function automatic int rreg();
    int x;
    x = $urandom_range(0, 4);
    return x == 4 ? 31 : x + 1;
  endfunction
  initial begin
    rst_n = 0; nop(); nop(); rst_n = 1;
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    issue(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); nop();
    issue(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); nop(); nop();
    issue(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    issue(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    issue(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 31, 1, 0, 0, 0);
    issue(1, 31, 1, 31, 1, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    issue(1, 5, 1, 2, 1, 6, 1, 0, 0, 0);
    issue(1, 5, 1, 2, 1, 6, 1, 0, 1, 0);
    nop();
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    repeat (3) issue(1, 1, 1, 1, 1, 2, 1, 0, 0, 1);
    issue(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
    issue(1, 2, 1, 1, 1, 3, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    issue(1, 4, 0, 5, 1, 6, 1, 0, 0, 0);
    rst_n = 0; nop(); rst_n = 1;
    nop();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      issue($urandom_range(0, 5) != 0, rreg(), $urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 1) != 0,
            rreg(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    rst_n = 1; nop();
    @(negedge clk); #1;
    if (xp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: actual=%0d required=0 pending expectations", xp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline controller for the 5-stage ARMv8 core. It sequences the EX-stage datapath by generating the registered forwardA/forwardB mux selects, load-use stalls, and branch flushes.
- It keeps its own shadow pipeline of destination-register metadata for the EX, MEM and WB stages, so it needs no pipeline-register taps beyond ID fields and the MEM-stage branch outcome.
- It sits beside the ID/EX pipeline register; its outputs drive PC/IF-ID write enables, bubble insertion and the execution stage's forwarding muxes.

Parameters:
- REG_ADDR_W, 5, register-address width.
- ZERO_REG, 31, XZR index; never a forwarding source or hazard.
- CNT_W, 32, width of performance counters (only with optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn  in  REG_ADDR_W  source operand A register.
- id_rm  in  REG_ADDR_W  source operand B register.
- id_uses_rn  in  1  instruction reads Rn.
- id_uses_rm  in  1  instruction reads Rm.
- id_rd  in  REG_ADDR_W  destination register.
- id_reg_write  in  1  instruction writes Rd.
- id_mem_read  in  1  instruction is a load.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- mem_busy  in  1  data memory not ready; freeze whole pipeline.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  zero ID/EX control fields this cycle.
- flush_if_id  out  1  invalidate IF/ID.
- flush_id_ex  out  1  invalidate ID/EX.
- flush_ex_mem  out  1  invalidate EX/MEM.
- forwardA  out  2  EX operand A select: 00 regfile, 10 EX/MEM result, 01 WB write-back.
- forwardB  out  2  EX operand B select, same encoding.

Behaviour:
- Shadow pipeline: ex_s, mem_s, wb_s, each {valid, reg_write, mem_read, rd}. On an advancing cycle: ex_s<=ID entry (or invalid if bubble/flush), mem_s<=ex_s, wb_s<=mem_s.
- Hazard-relevant: an entry is relevant only when valid=1, reg_write=1 and rd!=ZERO_REG.
- Forward select is computed from the current ex_s/mem_s and registered so it aligns with the instruction entering EX.
  - Rn matches relevant ex_s (becomes EX/MEM) -> forwardA<=10.
  - Else Rn matches relevant mem_s (becomes MEM/WB) -> forwardA<=01.
  - Else forwardA<=00. Same rules for Rm/forwardB.
  - EX/MEM always has priority over WB.
  - A match counts only if the corresponding id_uses_* bit is 1.
  - A WB-stage writer needs no forward: the regfile writes before it reads.
- FSM states: RUN, LOAD_STALL, FLUSH, FREEZE.
  - RUN: all write enables are 1, no flush.
  - RUN->LOAD_STALL when id_valid, relevant ex_s.mem_read=1, and rd matches a used Rn/Rm.
  - LOAD_STALL (exactly 1 cycle): pc_write=0, if_id_write=0, id_ex_bubble=1; ex_s<=invalid; forward selects <=00. Returns to RUN. The re-evaluated ID then sees the load in mem_s and gets 01.
  - RUN/LOAD_STALL->FLUSH when mem_branch_taken=1. FLUSH (1 cycle): flush_if_id=flush_id_ex=flush_ex_mem=1, pc_write=1; ex_s and mem_s <= invalid; forward selects <=00. Returns to RUN.
  - FREEZE while mem_busy=1: pc_write=if_id_write=0, no flush/bubble; shadows and forward selects hold. On deassert, return to RUN and re-evaluate.
- Priority: mem_busy > mem_branch_taken > load-use.
  - A branch arriving during a load-use hazard flushes and cancels the stall.
  - mem_busy masks a simultaneous branch; the branch input must be held until the freeze ends.
- Reset (rst_n=0 at clk edge): state=RUN, all shadows invalid, forwardA=forwardB=00, pc_write=if_id_write=1, id_ex_bubble and all flushes=0. Reset mid-stall or mid-flush aborts it immediately.
- id_valid=0: no hazard detected; the entry enters ex_s as invalid.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs stall_cnt, flush_cnt, freeze_cnt (CNT_W each).
  - Each counter increments once per cycle spent in LOAD_STALL, FLUSH or FREEZE respectively.
  - Counters wrap at 2^CNT_W and reset to 0.
- HAZARD_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_WB=2'b01; FSM state encoding; ZERO_REG constant; stage-metadata struct {valid, reg_write, mem_read, rd}.
- One natural sub-module: fwd_select (combinational comparator for a single operand against ex_s/mem_s), instantiated twice.

Test Plan:
- Write-write chain: ADD X1 then SUB X2,X1,X3 back-to-back -> forwardA=10 in SUB's EX cycle; after one intervening NOP -> forwardA=01; after two NOPs -> 00.
- Load-use: LDUR X5 then ADD X6,X5,X5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; then forwardA=forwardB=01 for ADD.
- Zero register: ADD X31 then use of X31 -> no stall, forwardA=00.
- Branch taken asserted during a load-use stall -> all three flushes =1 for one cycle, stall cancelled, forwards =00, state back to RUN.
- mem_busy held 3 cycles during a forwarding sequence -> pc_write=if_id_write=0 for 3 cycles, forward selects unchanged, correct forwarding resumes afterward.
- Reset asserted in LOAD_STALL -> next cycle: pc_write=1, id_ex_bubble=0, forwards=00; with HAZARD_PERF_EN defined, counters =0.
